// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: turns debug-console ASCII lines "<addr-hex> <data-hex>\n" into write requests.
// Optional build macro HEX_CMD_ECHO_EN adds a local-echo byte port (lowercase a-f upper-cased).
module hex_cmd_parser #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err_pulse,
  output logic [1:0]        err_code
`ifdef HEX_CMD_ECHO_EN
  ,
  output logic              echo_valid,
  output logic [7:0]        echo_data
`endif
);

  localparam int unsigned AddrDigits = ADDR_W / 4;
  localparam int unsigned DataDigits = DATA_W / 4;
  localparam int unsigned AddrCntW   = $clog2(AddrDigits + 1);
  localparam int unsigned DataCntW   = $clog2(DataDigits + 1);

  localparam logic [AddrCntW-1:0] AddrMax = AddrCntW'(AddrDigits);
  localparam logic [DataCntW-1:0] DataMax = DataCntW'(DataDigits);

  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChSp = 8'h20;

  localparam logic [1:0] ErrBadChar   = 2'd1;
  localparam logic [1:0] ErrTooMany   = 2'd2;
  localparam logic [1:0] ErrMissField = 2'd3;

  typedef enum logic [1:0] {StAddr, StData, StSkip, StEmit} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_acc_q, addr_acc_d;
  logic [DATA_W-1:0]   data_acc_q, data_acc_d;
  logic [AddrCntW-1:0] addr_cnt_q, addr_cnt_d;
  logic [DataCntW-1:0] data_cnt_q, data_cnt_d;
  logic                in_ready_q;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                err_pulse_q, err_pulse_d;
  logic [1:0]          err_code_q, err_code_d;

  logic       accept;
  logic       is_hex;
  logic [3:0] nibble;
  logic       clear_fields;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

  // ASCII hex digit decode (0-9, A-F, a-f).
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      nibble = in_data[3:0];
    end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                 (in_data >= 8'h61 && in_data <= 8'h66)) begin
      nibble = in_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Line parser next-state, field accumulation, request and error generation.
  always_comb begin
    state_d      = state_q;
    addr_acc_d   = addr_acc_q;
    data_acc_d   = data_acc_q;
    addr_cnt_d   = addr_cnt_q;
    data_cnt_d   = data_cnt_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    clear_fields = 1'b0;

    case (state_q)
      StAddr: begin
        // CR is dropped everywhere so CRLF terminals work unchanged.
        if (accept && in_data != ChCr) begin
          if (is_hex) begin
            if (addr_cnt_q == AddrMax) begin
              err_pulse_d = 1'b1;
              err_code_d  = ErrTooMany;
              state_d     = StSkip;
            end else begin
              addr_acc_d = (addr_acc_q << 4) | ADDR_W'(nibble);
              addr_cnt_d = addr_cnt_q + AddrCntW'(1);
            end
          end else if (in_data == ChSp) begin
            if (addr_cnt_q != '0) begin
              state_d = StData;
            end
          end else if (in_data == ChLf) begin
            if (addr_cnt_q != '0) begin
              err_pulse_d  = 1'b1;
              err_code_d   = ErrMissField;
              clear_fields = 1'b1;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ErrBadChar;
            state_d     = StSkip;
          end
        end
      end

      StData: begin
        if (accept && in_data != ChCr) begin
          if (is_hex) begin
            if (data_cnt_q == DataMax) begin
              err_pulse_d = 1'b1;
              err_code_d  = ErrTooMany;
              state_d     = StSkip;
            end else begin
              data_acc_d = (data_acc_q << 4) | DATA_W'(nibble);
              data_cnt_d = data_cnt_q + DataCntW'(1);
            end
          end else if (in_data == ChSp && data_cnt_q == '0) begin
            // Extra separator spaces before the data field are tolerated.
          end else if (in_data == ChLf) begin
            clear_fields = 1'b1;
            if (data_cnt_q != '0) begin
              out_valid_d = 1'b1;
              out_addr_d  = addr_acc_q;
              out_data_d  = data_acc_q;
              state_d     = StEmit;
            end else begin
              err_pulse_d = 1'b1;
              err_code_d  = ErrMissField;
              state_d     = StAddr;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ErrBadChar;
            state_d     = StSkip;
          end
        end
      end

      StSkip: begin
        if (accept && in_data == ChLf) begin
          clear_fields = 1'b1;
          state_d      = StAddr;
        end
      end

      StEmit: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAddr;
        end
      end

      default: begin
        state_d      = StAddr;
        clear_fields = 1'b1;
      end
    endcase

    if (clear_fields) begin
      addr_acc_d = '0;
      data_acc_d = '0;
      addr_cnt_d = '0;
      data_cnt_d = '0;
    end
  end

  // State and output registers; in_ready is computed from the next state so it drops
  // on the same edge that raises out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAddr;
      addr_acc_q  <= '0;
      data_acc_q  <= '0;
      addr_cnt_q  <= '0;
      data_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_acc_q  <= addr_acc_d;
      data_acc_q  <= data_acc_d;
      addr_cnt_q  <= addr_cnt_d;
      data_cnt_q  <= data_cnt_d;
      in_ready_q  <= (state_d != StEmit);
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef HEX_CMD_ECHO_EN
  logic       echo_valid_q;
  logic [7:0] echo_data_q;
  logic [7:0] echo_char;

  // Upper-case a-f so the echoed line matches the canonical hex form.
  always_comb begin
    echo_char = in_data;
    if (in_data >= 8'h61 && in_data <= 8'h66) begin
      echo_char = in_data - 8'h20;
    end
  end

  // Re-emit every accepted byte one cycle later; no backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
    end else begin
      echo_valid_q <= accept;
      if (accept) begin
        echo_data_q <= echo_char;
      end
    end
  end

  assign echo_valid = echo_valid_q;
  assign echo_data  = echo_data_q;
`endif

endmodule
